// File: rtl/uart_tx_dev_pkg.sv
// Shared definitions for the UART transmit device: register offsets, STATUS/CTRL
// bit positions, FSM state encoding and the divisor clamp helper.
package uart_tx_dev_pkg;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_CTRL   = 2'd1;
   localparam logic [1:0] ADDR_DIV    = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   localparam int STAT_BUSY = 0;
   localparam int STAT_DONE = 1;
   localparam int STAT_OVR  = 2;
   localparam int CTRL_IE   = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } txState_t;

   // Terminal count for a bit; a divisor of zero is treated as one cycle per bit.
   function automatic logic [15:0] bitLimit(input logic [15:0] div);
      return (div == 16'd0) ? 16'd0 : div - 16'd1;
   endfunction

endpackage

// File: rtl/uart_tx_dev_if.sv
// Bridge attachment for the UART transmit device, same shape as the timer device:
// register select, write strobe and data in; read data and level interrupt out.
interface uart_tx_dev_if;
   logic [3:2]  addr;
   logic        we;
   logic [31:0] DEV_WD;
   logic [31:0] DEVUart_RD;
   logic        IRQ;

   modport master (output addr, output we, output DEV_WD, input DEVUart_RD, input IRQ);
   modport slave  (input addr, input we, input DEV_WD, output DEVUart_RD, output IRQ);
endinterface

// File: rtl/uart_tx_dev_baud.sv
// Baud counter: latches the divisor on load, then emits a one-cycle bit-end pulse
// every max(div,1) enabled cycles.
module uart_baud_cnt
   import uart_tx_dev_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_load,
   input  logic [15:0] i_div,
   input  logic        i_en,
   output logic        o_bitEnd
);

   logic [15:0] r_lim;
   logic [15:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lim <= 16'd0;
         r_cnt <= 16'd0;
      end else if (i_load) begin
         r_lim <= bitLimit(i_div);
         r_cnt <= 16'd0;
      end else if (i_en) begin
         if (r_cnt == r_lim) r_cnt <= 16'd0;
         else                r_cnt <= r_cnt + 16'd1;
      end
   end

   assign o_bitEnd = i_en && (r_cnt == r_lim);

endmodule

// File: rtl/uart_tx_dev.sv
// UART transmitter device: four bridge-mapped registers driving an 8N1 serial
// frame generator with busy/done/overrun status and a done interrupt.
module uart_tx_dev
   import uart_tx_dev_pkg::*;
#(
   parameter logic [15:0] DIV_RST = 16'd16
) (
   input  logic           clk,
   input  logic           rst,
   uart_tx_dev_if.slave   bus,
   output logic           tx
);

   txState_t    r_state;
   logic        r_tx;
   logic [7:0]  r_data;
   logic [15:0] r_div;
   logic        r_ie;
   logic        r_busy;
   logic        r_done;
   logic        r_ovr;
   logic [2:0]  r_bitCnt;

   logic        w_wrData;
   logic        w_wrCtrl;
   logic        w_wrDiv;
   logic        w_wrStatus;
   logic        w_accept;
   logic        w_running;
   logic        w_bitEnd;
   logic [31:0] w_rdData;
   logic        w_unusedWd;

   assign w_wrData   = bus.we && (bus.addr == ADDR_DATA);
   assign w_wrCtrl   = bus.we && (bus.addr == ADDR_CTRL);
   assign w_wrDiv    = bus.we && (bus.addr == ADDR_DIV);
   assign w_wrStatus = bus.we && (bus.addr == ADDR_STATUS);
   assign w_accept   = w_wrData && (r_state == ST_IDLE);
   assign w_running  = (r_state != ST_IDLE);
   assign w_unusedWd = ^bus.DEV_WD[31:16];

   uart_baud_cnt u_baud (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_accept),
      .i_div    (r_div),
      .i_en     (w_running),
      .o_bitEnd (w_bitEnd)
   );

   // Frame events are written after the STATUS clear so a DONE set in the same cycle wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_tx     <= 1'b1;
         r_data   <= 8'd0;
         r_div    <= DIV_RST;
         r_ie     <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_ovr    <= 1'b0;
         r_bitCnt <= 3'd0;
      end else begin
         if (w_wrCtrl) r_ie <= bus.DEV_WD[CTRL_IE];
         if (w_wrDiv)  r_div <= bus.DEV_WD[15:0];
         if (w_wrStatus) begin
            r_done <= 1'b0;
            r_ovr  <= 1'b0;
         end
         if (w_wrData && w_running) r_ovr <= 1'b1;

         case (r_state)
            ST_IDLE: begin
               if (w_wrData) begin
                  r_data  <= bus.DEV_WD[7:0];
                  r_busy  <= 1'b1;
                  r_tx    <= 1'b0;
                  r_state <= ST_START;
               end
            end
            ST_START: begin
               if (w_bitEnd) begin
                  r_tx     <= r_data[0];
                  r_bitCnt <= 3'd0;
                  r_state  <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_bitEnd) begin
                  if (r_bitCnt == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= ST_STOP;
                  end else begin
                     r_tx     <= r_data[r_bitCnt + 3'd1];
                     r_bitCnt <= r_bitCnt + 3'd1;
                  end
               end
            end
            ST_STOP: begin
               if (w_bitEnd) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_rdData = 32'd0;
      case (bus.addr)
         ADDR_DATA:   w_rdData[7:0]  = r_data;
         ADDR_CTRL:   w_rdData[CTRL_IE] = r_ie;
         ADDR_DIV:    w_rdData[15:0] = r_div;
         ADDR_STATUS: begin
            w_rdData[STAT_BUSY] = r_busy;
            w_rdData[STAT_DONE] = r_done;
            w_rdData[STAT_OVR]  = r_ovr;
         end
         default:     w_rdData = 32'd0;
      endcase
   end

   assign bus.DEVUart_RD = w_rdData;
   assign bus.IRQ        = r_done & r_ie;
   assign tx             = r_tx;

endmodule

// File: tb/tb_uart_tx_dev.sv
// Scoreboard bench for uart_tx_dev: register traffic is driven directly while a
// line monitor decodes every frame on tx against the queue of expected frames.
module tb_uart_tx_dev;
   import uart_tx_dev_pkg::*;

   typedef struct {
      logic [7:0] data;
      int         div;
      bit         aborted;
   } frame_t;

   logic clk = 1'b0;
   logic rst;
   logic tx;
   int   cycleCnt = 0;
   int   total = 0;
   int   bad = 0;
   frame_t expQ[$];

   uart_tx_dev_if bus();

   uart_tx_dev #(.DIV_RST(16'd16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus),
      .tx  (tx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.we = 1'b1;
      bus.addr = a;
      bus.DEV_WD = d;
      @(negedge clk);
      bus.we = 1'b0;
   endtask

   task automatic readReg(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      bus.addr = a;
      #1;
      d = bus.DEVUart_RD;
   endtask

   task automatic pushFrame(input logic [7:0] d, input int v, input bit ab);
      frame_t f;
      f.data = d;
      f.div = v;
      f.aborted = ab;
      expQ.push_back(f);
   endtask

   // Polls BUSY at negedges; returns cycles elapsed since t0 when it first reads low.
   task automatic waitIdle(input int t0, output int len);
      len = -1;
      for (int i = 0; i < 3000; i++) begin
         bus.addr = ADDR_STATUS;
         #1;
         if (bus.DEVUart_RD[STAT_BUSY] == 1'b0) begin
            len = cycleCnt - t0;
            break;
         end
         @(negedge clk);
      end
      if (len < 0) checkOutput("busy wait bound", 32'(bus.DEVUart_RD[STAT_BUSY]), 32'd0);
   endtask

   logic   monPrevTx;
   logic   monExpBit;
   logic   monOk;
   bit     monAbort;
   frame_t monFrame;

   // Each bit must hold its level for exactly div sampled cycles.
   initial begin
      monPrevTx = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst && monPrevTx === 1'b1 && tx === 1'b0) begin
            if (expQ.size() == 0) begin
               checkOutput("frame expected", 32'(expQ.size()), 32'd1);
               for (int i = 0; i < 2000 && tx !== 1'b1; i++) @(negedge clk);
            end else begin
               monFrame = expQ.pop_front();
               monAbort = 1'b0;
               for (int b = 0; b < 10 && !monAbort; b++) begin
                  monExpBit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : monFrame.data[b-1];
                  monOk = 1'b1;
                  for (int c = 0; c < monFrame.div; c++) begin
                     if (b != 0 || c != 0) @(negedge clk);
                     if (rst) begin
                        monAbort = 1'b1;
                        break;
                     end
                     if (tx !== monExpBit) monOk = 1'b0;
                  end
                  if (!monAbort)
                     checkOutput($sformatf("frame 0x%02h bit %0d", monFrame.data, b), 32'(monOk), 32'd1);
               end
               checkOutput($sformatf("frame 0x%02h aborted", monFrame.data), 32'(monAbort), 32'(monFrame.aborted));
            end
         end
         monPrevTx = tx;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [31:0] rd;
      int t0;
      int len;
      bus.we = 1'b0;
      bus.addr = ADDR_DATA;
      bus.DEV_WD = 32'd0;
      rst = 1'b1;
      repeat (3) @(negedge clk);

      checkOutput("reset tx", 32'(tx), 32'd1);
      checkOutput("reset IRQ", 32'(bus.IRQ), 32'd0);
      bus.addr = ADDR_STATUS; #1;
      checkOutput("reset STATUS", bus.DEVUart_RD, 32'd0);
      bus.addr = ADDR_DIV; #1;
      checkOutput("reset DIV", bus.DEVUart_RD, 32'd16);
      bus.addr = ADDR_DATA; #1;
      checkOutput("reset DATA", bus.DEVUart_RD, 32'd0);
      bus.addr = ADDR_CTRL; #1;
      checkOutput("reset CTRL", bus.DEVUart_RD, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // 0xA5 at four cycles per bit
      applyStimulus(ADDR_DIV, 32'd4);
      pushFrame(8'hA5, 4, 1'b0);
      applyStimulus(ADDR_DATA, 32'hA5);
      t0 = cycleCnt;
      waitIdle(t0, len);
      checkOutput("A5 busy cycles", 32'(len), 32'd40);
      readReg(ADDR_STATUS, rd);
      checkOutput("A5 STATUS after", rd, 32'h2);
      readReg(ADDR_DATA, rd);
      checkOutput("A5 DATA readback", rd, 32'hA5);

      // interrupt follows DONE while enabled
      applyStimulus(ADDR_CTRL, 32'd1);
      checkOutput("IRQ with old DONE", 32'(bus.IRQ), 32'd1);
      applyStimulus(ADDR_STATUS, 32'd0);
      checkOutput("IRQ after STATUS clear", 32'(bus.IRQ), 32'd0);
      pushFrame(8'h3C, 4, 1'b0);
      applyStimulus(ADDR_DATA, 32'h3C);
      t0 = cycleCnt;
      repeat (10) @(negedge clk);
      checkOutput("IRQ mid frame", 32'(bus.IRQ), 32'd0);
      waitIdle(t0, len);
      checkOutput("3C busy cycles", 32'(len), 32'd40);
      checkOutput("IRQ at done", 32'(bus.IRQ), 32'd1);
      applyStimulus(ADDR_STATUS, 32'd0);
      checkOutput("IRQ after ack", 32'(bus.IRQ), 32'd0);
      applyStimulus(ADDR_CTRL, 32'd0);

      // second write during a frame is dropped and flags overrun
      pushFrame(8'h11, 4, 1'b0);
      applyStimulus(ADDR_DATA, 32'h11);
      t0 = cycleCnt;
      repeat (8) @(negedge clk);
      applyStimulus(ADDR_DATA, 32'h22);
      readReg(ADDR_STATUS, rd);
      checkOutput("OVR STATUS mid", rd, 32'h5);
      readReg(ADDR_DATA, rd);
      checkOutput("OVR DATA kept", rd, 32'h11);
      waitIdle(t0, len);
      checkOutput("11 busy cycles", 32'(len), 32'd40);
      readReg(ADDR_STATUS, rd);
      checkOutput("OVR STATUS after", rd, 32'h6);

      // DIV=0 behaves as one cycle per bit
      applyStimulus(ADDR_STATUS, 32'd0);
      applyStimulus(ADDR_DIV, 32'd0);
      pushFrame(8'hFF, 1, 1'b0);
      applyStimulus(ADDR_DATA, 32'hFF);
      t0 = cycleCnt;
      waitIdle(t0, len);
      checkOutput("DIV0 busy cycles", 32'(len), 32'd10);
      readReg(ADDR_DIV, rd);
      checkOutput("DIV0 readback", rd, 32'd0);

      // divisor change mid-frame applies only to the next frame
      applyStimulus(ADDR_STATUS, 32'd0);
      applyStimulus(ADDR_DIV, 32'd8);
      pushFrame(8'h55, 8, 1'b0);
      applyStimulus(ADDR_DATA, 32'h55);
      t0 = cycleCnt;
      repeat (5) @(negedge clk);
      applyStimulus(ADDR_DIV, 32'd2);
      waitIdle(t0, len);
      checkOutput("DIV8 busy cycles", 32'(len), 32'd80);
      readReg(ADDR_DIV, rd);
      checkOutput("DIV2 readback", rd, 32'd2);
      pushFrame(8'h55, 2, 1'b0);
      applyStimulus(ADDR_DATA, 32'h55);
      t0 = cycleCnt;
      waitIdle(t0, len);
      checkOutput("DIV2 busy cycles", 32'(len), 32'd20);

      // DATA write on the STOP->IDLE edge is an overrun
      applyStimulus(ADDR_STATUS, 32'd0);
      pushFrame(8'h0F, 2, 1'b0);
      applyStimulus(ADDR_DATA, 32'h0F);
      repeat (18) @(negedge clk);
      applyStimulus(ADDR_DATA, 32'hAA);
      readReg(ADDR_STATUS, rd);
      checkOutput("edge write STATUS", rd, 32'h6);
      readReg(ADDR_DATA, rd);
      checkOutput("edge write DATA kept", rd, 32'h0F);
      repeat (30) @(negedge clk);
      readReg(ADDR_STATUS, rd);
      checkOutput("edge write no frame", rd, 32'h6);

      // STATUS clear on the DONE-setting edge leaves DONE set
      applyStimulus(ADDR_STATUS, 32'd0);
      pushFrame(8'hC3, 2, 1'b0);
      applyStimulus(ADDR_DATA, 32'hC3);
      repeat (18) @(negedge clk);
      applyStimulus(ADDR_STATUS, 32'd0);
      readReg(ADDR_STATUS, rd);
      checkOutput("DONE wins clear", rd, 32'h2);

      // asynchronous reset mid-frame while tx is low
      applyStimulus(ADDR_DIV, 32'd4);
      applyStimulus(ADDR_STATUS, 32'd0);
      pushFrame(8'h6B, 4, 1'b1);
      applyStimulus(ADDR_DATA, 32'h6B);
      repeat (14) @(negedge clk);
      checkOutput("tx low before reset", 32'(tx), 32'd0);
      #2 rst = 1'b1;
      #1 checkOutput("abort tx", 32'(tx), 32'd1);
      bus.addr = ADDR_STATUS; #1;
      checkOutput("abort STATUS", bus.DEVUart_RD, 32'd0);
      bus.addr = ADDR_DIV; #1;
      checkOutput("abort DIV", bus.DEVUart_RD, 32'd16);
      bus.addr = ADDR_DATA; #1;
      checkOutput("abort DATA", bus.DEVUart_RD, 32'd0);
      @(negedge clk);
      #2 rst = 1'b0;

      repeat (20) @(negedge clk);
      checkOutput("idle tx at end", 32'(tx), 32'd1);
      checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
